// File: rtl/sin_phase_gen.sv
// rtl/sin_phase_gen.sv - phase accumulator driving a sine LUT index, with sample capture and PWM output
module sin_phase_gen #(
   parameter int ACC_W   = 16,
   parameter int DIV_W   = 16,
   parameter int LUT_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [ACC_W-1:0] tune,
   input  logic [DIV_W-1:0] div,
   output logic [8:0]       count,
   input  logic [7:0]       val,
   output logic [7:0]       sample,
   output logic             sample_vld,
   output logic             wrap,
   output logic             pwm
);

   localparam int DCW = $clog2(LUT_LAT + 2) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_nx;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic [DIV_W-1:0] presc;
   logic [7:0]       pwm_cnt;
   logic [LUT_LAT+1:0] pipe;
   logic [DCW-1:0]   dcnt;
   logic             tick;
   logic             drain_done;
   logic             clr;

   assign sum        = {1'b0, acc} + {1'b0, tune};
   assign tick       = (state == RUN) && (presc >= div);
   assign drain_done = (dcnt == DCW'(LUT_LAT + 1));
   assign clr        = (state == DRAIN) && (state_nx == IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (en) state_nx = RUN;
         RUN:     if (!en) state_nx = DRAIN;
         DRAIN:   if (en) state_nx = RUN;
                  else if (drain_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dcnt  <= '0;
      end else begin
         state <= state_nx;
         if (state != DRAIN)
            dcnt <= '0;
         else if (!en)
            dcnt <= dcnt + 1'b1;
      end
   end

   // ">=" compare lets a shrinking div retire immediately instead of waiting for a 2^DIV_W rollover
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         acc     <= '0;
         count   <= '0;
         wrap    <= 1'b0;
         pwm_cnt <= '0;
      end else begin
         wrap <= tick & sum[ACC_W];
         if (clr) begin
            presc   <= '0;
            acc     <= '0;
            count   <= '0;
            pwm_cnt <= '0;
         end else begin
            if (state == RUN)
               presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
               acc   <= sum[ACC_W-1:0];
               count <= sum[ACC_W-1 -: 9];
            end
            if (state != IDLE)
               pwm_cnt <= pwm_cnt + 1'b1;
         end
      end
   end

   // One valid bit per tick marches down the pipe; val is taken when the LUT has caught up with count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe   <= '0;
         sample <= '0;
      end else begin
         pipe <= {pipe[LUT_LAT:0], tick};
         if (pipe[LUT_LAT])
            sample <= val;
      end
   end

   assign sample_vld = pipe[LUT_LAT+1];
   assign pwm        = (state != IDLE) && (pwm_cnt < sample);

endmodule

// File: tb/tb_sin_phase_gen.sv
// tb/tb_sin_phase_gen.sv - directed bench for sin_phase_gen with a 1-cycle LUT model
module tb_sin_phase_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] tune = '0;
   logic [15:0] div = '0;
   logic [8:0]  count;
   logic [7:0]  val = '0;
   logic [7:0]  sample;
   logic        sample_vld;
   logic        wrap;
   logic        pwm;
   logic        const_mode = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n;
   logic [15:0] acc_exp;

   sin_phase_gen #(.ACC_W(16), .DIV_W(16), .LUT_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .tune(tune), .div(div),
      .count(count), .val(val), .sample(sample), .sample_vld(sample_vld),
      .wrap(wrap), .pwm(pwm)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lut(input logic [8:0] c);
      logic [7:0] m;
      m = c[7:0] * 8'd3;
      return m ^ {c[8], 7'h25};
   endfunction

   // LUT with one cycle of latency from count to val
   always_ff @(posedge clk)
      val <= const_mode ? 8'h40 : lut(count);

   task automatic step;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] t, input logic [15:0] d, input logic cm);
      en = 1'b0;
      rst_n = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      tune = t;
      div = d;
      const_mode = cm;
      en = 1'b1;
      cyc = 0;
   endtask

   initial begin
      step;
      chk("rst_count", count, 0);
      chk("rst_sample", sample, 0);
      chk("rst_vld", sample_vld, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_pwm", pwm, 0);

      // tune=0x80, div=0: count k-1 at cycle k, strobes from cycle 4, single wrap at 511->0
      start(16'h0080, 16'd0, 1'b0);
      for (int k = 1; k <= 520; k++) begin
         step;
         chk("t1_count", count, (k >= 2) ? ((k - 1) % 512) : 0);
         chk("t1_vld", sample_vld, (k >= 4) ? 1 : 0);
         if (k >= 4) chk("t1_sample", sample, lut(9'((k - 3) % 512)));
         chk("t2_wrap", wrap, (k == 513) ? 1 : 0);
      end

      // div=3: one tick every 4 cycles
      start(16'h0080, 16'd3, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         step;
         chk("t3_count", count, (k - 1) / 4);
         chk("t3_vld", sample_vld, (k >= 7 && (k - 7) % 4 == 0) ? 1 : 0);
      end

      // tune=FFFF: acc counts down from FFFF, carry on every tick after the first
      start(16'hFFFF, 16'd0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step;
         if (k >= 2) begin
            acc_exp = 16'(17'h10000 - (k - 1));
            chk("t4_count", count, acc_exp[15:7]);
            chk("t4_wrap", wrap, (k >= 3) ? 1 : 0);
         end
      end

      // drop en mid-run, drain, then resume from a retained acc
      start(16'h0080, 16'd0, 1'b0);
      repeat (10) step;
      chk("t5_pre", count, 9);
      en = 1'b0;
      n = 0;
      for (int k = 11; k <= 20; k++) begin
         step;
         n += sample_vld;
         if (k == 13) chk("t5_drain_count", count, 10);
         if (k == 14) begin
            chk("t5_idle_count", count, 0);
            chk("t5_idle_pwm", pwm, 0);
         end
      end
      chk("t5_strobes", n, 3);
      en = 1'b1;
      repeat (5) step;
      chk("t5_run2", count, 4);
      en = 1'b0;
      step;
      chk("t5_drain2", count, 5);
      en = 1'b1;
      step;
      chk("t5_resume_a", count, 5);
      step;
      chk("t5_resume_b", count, 6);

      // constant LUT 0x40: 64 of 256 pwm cycles high, then async reset mid-run
      start(16'h0080, 16'd0, 1'b1);
      repeat (10) step;
      chk("t6_sample", sample, 8'h40);
      n = 0;
      repeat (256) begin
         step;
         n += pwm;
      end
      chk("t6_pwm_high", n, 64);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", count, 0);
      chk("t6_rst_sample", sample, 0);
      chk("t6_rst_vld", sample_vld, 0);
      chk("t6_rst_wrap", wrap, 0);
      chk("t6_rst_pwm", pwm, 0);
      step;
      chk("t6_rst_hold", count, 0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
